// File: rtl/tick_sched_pkg.sv
// Shared defaults and helpers for the tick scheduler.
// Optional feature macro: TICK_SCHED_ONESHOT_EN (see tick_scheduler.sv).
package tick_sched_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int PRE_DIV_DEF = 49;
    localparam int CNT_W_DEF   = 16;

    // Channel index width; a single channel still needs a 1-bit index port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flag portion of the per-channel record; the counter fields are
    // parameter-sized and are added alongside these in tick_scheduler.
    typedef struct packed {
        logic en;
        logic oneshot;
        logic clkout;
    } ch_flags_t;

endpackage

// File: rtl/tick_prescaler.sv
// Shared free-running timebase: base_tick is high for one cycle in every
// PRE_DIV+1 cycles of clk50.
module tick_prescaler #(
    parameter int PRE_DIV = 49
) (
    input  logic clk50,
    input  logic rst_n,
    output logic base_tick
);

    localparam int PW = (PRE_DIV > 0) ? $clog2(PRE_DIV + 1) : 1;

    logic [PW-1:0] pre_cnt;

    assign base_tick = (pre_cnt == PW'(PRE_DIV));

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (base_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// N_CH programmable slow-clock channels sharing one prescaler; each emits a
// tick pulse and a toggle clock. `define TICK_SCHED_ONESHOT_EN adds cfg_oneshot.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEF,
    parameter  int PRE_DIV = PRE_DIV_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int CH_W    = ch_w(N_CH)
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_en,
`ifdef TICK_SCHED_ONESHOT_EN
    input  logic             cfg_oneshot,
`endif
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clkout,
    output logic [N_CH-1:0]  active
);

    typedef struct packed {
        ch_flags_t        flags;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] cnt;
    } ch_state_t;

    logic base_tick;
    logic cfg_fire;
    logic os_in;

    tick_prescaler #(
        .PRE_DIV(PRE_DIV)
    ) u_prescaler (
        .clk50    (clk50),
        .rst_n    (rst_n),
        .base_tick(base_tick)
    );

    // Handshake: a write transfers on the rising edge where cfg_valid && cfg_ready.
    // Ready drops only during base_tick, so a write never races a count update.
    assign cfg_ready = ~base_tick;
    assign cfg_fire  = cfg_valid & cfg_ready;

`ifdef TICK_SCHED_ONESHOT_EN
    assign os_in = cfg_oneshot;
`else
    assign os_in = 1'b0;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ch_state_t st;
        logic      tick_q;
        logic      wr_hit;

        // Out-of-range channel indices match no channel and are dropped.
        assign wr_hit = cfg_fire && (cfg_ch == CH_W'(k));

        always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
                st     <= '0;
                tick_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (wr_hit) begin
                    st.flags.en      <= cfg_en;
                    st.flags.oneshot <= os_in;
                    st.flags.clkout  <= 1'b0;
                    st.period        <= cfg_period;
                    st.cnt           <= '0;
                end else if (base_tick && st.flags.en) begin
                    if (st.cnt == st.period) begin
                        st.cnt          <= '0;
                        tick_q          <= 1'b1;
                        st.flags.clkout <= ~st.flags.clkout;
                        if (st.flags.oneshot) begin
                            st.flags.en <= 1'b0;
                        end
                    end else begin
                        st.cnt <= st.cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign tick[k]   = tick_q;
        assign clkout[k] = st.flags.clkout;
        assign active[k] = st.flags.en;
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler (N_CH=4, PRE_DIV=3, CNT_W=8); define
// TICK_SCHED_ONESHOT_EN to also exercise the oneshot feature.
module tb_tick_scheduler;

    localparam int N_CH    = 4;
    localparam int PRE_DIV = 3;
    localparam int CNT_W   = 8;
    localparam int CH_W    = 2;
    localparam int DIV     = PRE_DIV + 1;

    logic             clk50 = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             cfg_en = 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
    logic             cfg_oneshot = 1'b0;
`endif
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  clkout;
    logic [N_CH-1:0]  active;

    int n_cmp = 0;
    int n_err = 0;
    int pc;
    int m_en[N_CH];
    int m_per[N_CH];
    int m_acc[N_CH];
    int m_os[N_CH];
    logic [31:0] exp_q[$];

    tick_scheduler #(
        .N_CH   (N_CH),
        .PRE_DIV(PRE_DIV),
        .CNT_W  (CNT_W)
    ) dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_en    (cfg_en),
`ifdef TICK_SCHED_ONESHOT_EN
        .cfg_oneshot(cfg_oneshot),
`endif
        .tick      (tick),
        .clkout    (clkout),
        .active    (active)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk50 = ~clk50;

    // pc = rising edges since reset release; prescaler phase is pc % DIV.
    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) pc <= 0;
        else        pc <= pc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running exp finished");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_en[ch] = 0; m_per[ch] = 0; m_acc[ch] = 0; m_os[ch] = 0;
        end
    endfunction

    // Number of expiries visible by cycle c for a channel written at edge m_acc.
    function automatic int n_fires(input int ch, input int c);
        int f;
        int n;
        if (m_en[ch] == 0) return 0;
        f = m_acc[ch] + (PRE_DIV - (m_acc[ch] % DIV));
        if (c - 1 < f) return 0;
        n = ((c - 1 - f) / DIV + 1) / (m_per[ch] + 1);
        if (m_os[ch] != 0 && n > 1) n = 1;
        return n;
    endfunction

    function automatic logic exp_tick(input int ch, input int c);
        return n_fires(ch, c) != n_fires(ch, c - 1);
    endfunction

    function automatic logic exp_clk(input int ch, input int c);
        return (n_fires(ch, c) % 2) == 1;
    endfunction

    function automatic logic exp_act(input int ch, input int c);
        return (m_en[ch] != 0) && !(m_os[ch] != 0 && n_fires(ch, c) >= 1);
    endfunction

    // ---------------- driver ----------------
    // Called and returns at a falling edge; records the accepting edge in the model.
    task automatic cfg_write(input int ch, input int per, input bit en, input bit os);
        int n;
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(per);
        cfg_en     = en;
`ifdef TICK_SCHED_ONESHOT_EN
        cfg_oneshot = os;
`endif
        n = 0;
        while (cfg_ready !== 1'b1 && n < 8) begin
            @(negedge clk50);
            n++;
        end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_write_ready ch%0d: got %b exp 1 within 8 cycles", ch, cfg_ready);
        end
        @(posedge clk50);
        #1;
        cfg_valid = 1'b0;
        if (ch < N_CH) begin
            m_en[ch] = int'(en); m_per[ch] = per; m_acc[ch] = pc; m_os[ch] = int'(os);
        end
        @(negedge clk50);
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while ((pc % DIV) != ph && n < 2 * DIV) begin
            @(negedge clk50);
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk50);
        n_cmp++; if (tick !== 4'b0)   begin n_err++; $display("FAIL por_tick: got %b exp 0000", tick); end
        n_cmp++; if (clkout !== 4'b0) begin n_err++; $display("FAIL por_clkout: got %b exp 0000", clkout); end
        n_cmp++; if (active !== 4'b0) begin n_err++; $display("FAIL por_active: got %b exp 0000", active); end
        rst_n = 1'b1;
        model_clear();
        cfg_write(0, 3, 1'b1, 1'b0);
        repeat (21) @(negedge clk50);
        n_cmp++; if (active[0] !== 1'b1) begin n_err++; $display("FAIL pre_rst_active0: got %b exp 1", active[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tick !== 4'b0)   begin n_err++; $display("FAIL midrst_tick: got %b exp 0000", tick); end
        n_cmp++; if (clkout !== 4'b0) begin n_err++; $display("FAIL midrst_clkout: got %b exp 0000", clkout); end
        n_cmp++; if (active !== 4'b0) begin n_err++; $display("FAIL midrst_active: got %b exp 0000", active); end
        @(negedge clk50);
        rst_n = 1'b1;
        model_clear();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b exp 1", cfg_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            n_cmp++; if (tick !== 4'b0) begin n_err++; $display("FAIL rel_tick cyc%0d: got %b exp 0000", pc, tick); end
            n_cmp++; if (active !== 4'b0) begin n_err++; $display("FAIL rel_active cyc%0d: got %b exp 0000", pc, active); end
            n_cmp++;
            if (cfg_ready !== ((pc % DIV) != PRE_DIV)) begin
                n_err++; $display("FAIL rel_ready cyc%0d: got %b exp %b", pc, cfg_ready, (pc % DIV) != PRE_DIV);
            end
        end
    endtask

    task automatic test_period0();
        int cnt0;
        cnt0 = 0;
        cfg_write(0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk50);
            if (tick[0] === 1'b1) cnt0++;
            n_cmp++; if (tick[0] !== exp_tick(0, pc)) begin n_err++; $display("FAIL p0_tick cyc%0d: got %b exp %b", pc, tick[0], exp_tick(0, pc)); end
            n_cmp++; if (clkout[0] !== exp_clk(0, pc)) begin n_err++; $display("FAIL p0_clkout cyc%0d: got %b exp %b", pc, clkout[0], exp_clk(0, pc)); end
            n_cmp++; if (active[0] !== 1'b1) begin n_err++; $display("FAIL p0_active cyc%0d: got %b exp 1", pc, active[0]); end
        end
        n_cmp++; if (cnt0 != 10) begin n_err++; $display("FAIL p0_tick_count: got %0d exp 10", cnt0); end
    endtask

    task automatic test_concurrent();
        int base;
        logic [31:0] e;
        wait_phase(0);
        base = pc;
        cfg_write(1, 2, 1'b1, 1'b0);
        cfg_write(2, 5, 1'b1, 1'b0);
        exp_q.push_back(32'(base + 24));
        exp_q.push_back(32'(base + 48));
        while (pc < base + 60) begin
            @(negedge clk50);
            for (int ch = 0; ch < 3; ch++) begin
                n_cmp++; if (tick[ch] !== exp_tick(ch, pc)) begin n_err++; $display("FAIL cc_tick ch%0d cyc%0d: got %b exp %b", ch, pc, tick[ch], exp_tick(ch, pc)); end
                n_cmp++; if (clkout[ch] !== exp_clk(ch, pc)) begin n_err++; $display("FAIL cc_clkout ch%0d cyc%0d: got %b exp %b", ch, pc, clkout[ch], exp_clk(ch, pc)); end
            end
            if (tick[1] === 1'b1 && tick[2] === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL cc_coincide: got extra at cyc%0d exp none", pc);
                end else begin
                    e = exp_q.pop_front();
                    if (32'(pc) !== e) begin n_err++; $display("FAIL cc_coincide: got cyc%0d exp cyc%0d", pc, e); end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL cc_coincide_missing: got %0d left exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_held_valid();
        wait_phase(PRE_DIV);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd1; cfg_en = 1'b1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL hv_ready_low: got %b exp 0", cfg_ready); end
        @(posedge clk50); #1;
        n_cmp++; if (active[3] !== 1'b0) begin n_err++; $display("FAIL hv_not_taken: got %b exp 0", active[3]); end
        @(negedge clk50);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hv_ready_high: got %b exp 1", cfg_ready); end
        @(posedge clk50); #1;
        cfg_valid = 1'b0;
        m_en[3] = 1; m_per[3] = 1; m_acc[3] = pc; m_os[3] = 0;
        n_cmp++; if (active[3] !== 1'b1) begin n_err++; $display("FAIL hv_taken: got %b exp 1", active[3]); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk50);
            for (int ch = 0; ch < N_CH; ch++) begin
                n_cmp++; if (tick[ch] !== exp_tick(ch, pc)) begin n_err++; $display("FAIL hv_tick ch%0d cyc%0d: got %b exp %b", ch, pc, tick[ch], exp_tick(ch, pc)); end
                n_cmp++; if (clkout[ch] !== exp_clk(ch, pc)) begin n_err++; $display("FAIL hv_clkout ch%0d cyc%0d: got %b exp %b", ch, pc, clkout[ch], exp_clk(ch, pc)); end
            end
        end
    endtask

    task automatic test_disable_and_ch3();
        cfg_write(0, 0, 1'b0, 1'b0);
        n_cmp++; if (clkout[0] !== 1'b0) begin n_err++; $display("FAIL dis_clkout0: got %b exp 0", clkout[0]); end
        n_cmp++; if (active[0] !== 1'b0) begin n_err++; $display("FAIL dis_active0: got %b exp 0", active[0]); end
        cfg_write(3, 7, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk50);
            for (int ch = 0; ch < N_CH; ch++) begin
                n_cmp++; if (tick[ch] !== exp_tick(ch, pc)) begin n_err++; $display("FAIL dc_tick ch%0d cyc%0d: got %b exp %b", ch, pc, tick[ch], exp_tick(ch, pc)); end
                n_cmp++; if (clkout[ch] !== exp_clk(ch, pc)) begin n_err++; $display("FAIL dc_clkout ch%0d cyc%0d: got %b exp %b", ch, pc, clkout[ch], exp_clk(ch, pc)); end
                n_cmp++; if (active[ch] !== exp_act(ch, pc)) begin n_err++; $display("FAIL dc_active ch%0d cyc%0d: got %b exp %b", ch, pc, active[ch], exp_act(ch, pc)); end
            end
        end
    endtask

`ifdef TICK_SCHED_ONESHOT_EN
    task automatic test_oneshot();
        int cnt1;
        for (int r = 0; r < 2; r++) begin
            cnt1 = 0;
            cfg_write(1, 1, 1'b1, 1'b1);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk50);
                if (tick[1] === 1'b1) cnt1++;
                n_cmp++; if (tick[1] !== exp_tick(1, pc)) begin n_err++; $display("FAIL os_tick cyc%0d: got %b exp %b", pc, tick[1], exp_tick(1, pc)); end
                n_cmp++; if (active[1] !== exp_act(1, pc)) begin n_err++; $display("FAIL os_active cyc%0d: got %b exp %b", pc, active[1], exp_act(1, pc)); end
            end
            n_cmp++; if (cnt1 != 1) begin n_err++; $display("FAIL os_tick_count round%0d: got %0d exp 1", r, cnt1); end
            n_cmp++; if (active[1] !== 1'b0) begin n_err++; $display("FAIL os_active_end round%0d: got %b exp 0", r, active[1]); end
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_period0();
        test_concurrent();
        test_held_valid();
        test_disable_and_ch3();
`ifdef TICK_SCHED_ONESHOT_EN
        test_oneshot();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
